python_spi_master: RTL and testbench
====================================

# python_spi_master

Serializes 26-bit register commands (9-bit address, write flag, 16-bit data) onto the PYTHON300 image sensor's 4-wire SPI port. For reads, it returns the 16-bit register value. It sits on the command side of the I2C-to-register bridge and consumes that bridge's SPI command channel (`addr`/`we`/`wdata`/`valid`/`ready`, with `rdata`/`rvalid` returned). It is the only agent driving the sensor SPI pins.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per SCK half-period; must be ≥1.
- `CS_SETUP`, 2: `clk` cycles from `spi_ss_n` falling to the first SCK rise region (start of bit 25 low phase); must be ≥1.
- `CS_HOLD`, 2: `clk` cycles from the last SCK fall to `spi_ss_n` rising; must be ≥1.
- `IDLE_GAP`, 4: `clk` cycles `spi_ss_n` stays high before the next command is accepted; must be ≥0.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_addr` in 9: sensor register address.
- `s_we` in 1: 1 = write, 0 = read.
- `s_wdata` in 16: write data; ignored for reads.
- `s_valid` in 1: command valid.
- `s_ready` out 1: command accept.
- `m_rdata` out 16: read result.
- `m_rvalid` out 1: one-cycle read-result strobe.
- `spi_ss_n` out 1: sensor chip select, active-low.
- `spi_sck` out 1: SPI clock; idles low.
- `spi_mosi` out 1: master data out.
- `spi_miso` in 1: sensor data out.

Reset values: `s_ready`=0, `m_rdata`=0, `m_rvalid`=0, `spi_ss_n`=1, `spi_sck`=0, `spi_mosi`=0. All outputs are registered.

## Operation
- State machine: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- **IDLE**
  - `s_ready`=1.
  - On `s_valid && s_ready`, latch `frame = {s_addr, s_we, s_wdata}` (26 bits, sent MSB first).
  - In the same edge: deassert `s_ready`, assert `spi_ss_n`=0, drive `spi_mosi`=`frame[25]`, go to SETUP.
- **SETUP**: hold for `CS_SETUP` cycles with SCK low, then go to SHIFT.
- **SHIFT**: 26 bits, index 25 down to 0. Each bit is `CLK_DIV` cycles SCK low, then `CLK_DIV` cycles SCK high.
  - `spi_mosi` updates only at the edge that drives SCK low (bit start). The sensor samples on SCK rise.
  - For reads, MOSI is driven 0 during bits 15..0.
  - For reads, `spi_miso` is sampled at the `clk` edge that drives SCK high, for bits 15..0. It is shifted into a 16-bit capture register, MSB first.
  - After bit 0's high phase, SCK goes low and the state moves to HOLD.
- **HOLD**: `CS_HOLD` cycles with SCK low, then `spi_ss_n`=1 and `spi_mosi`=0.
  - For a read, the same edge loads `m_rdata` with the capture register and pulses `m_rvalid` for exactly one cycle.
  - Writes never pulse `m_rvalid`.
- **GAP**: `IDLE_GAP` cycles (skipped if 0), then `s_ready`=1 in IDLE.
- `m_rdata` holds its value until the next read completes.
- Counters:
  - Divider counter: `$clog2(CLK_DIV)+1` bits.
  - Bit counter: 5 bits, 25..0, no wrap. Reaching 0 ends SHIFT.
  - Phase counter: shared by SETUP, HOLD and GAP, sized for max(`CS_SETUP`, `CS_HOLD`, `IDLE_GAP`).
- Commands presented while `s_ready`=0 are stalled, not dropped. `s_valid` and its payload must stay stable until accepted.
- Reset assertion at any point, including mid-SHIFT, immediately forces all outputs to reset values. The in-flight frame is discarded and no `m_rvalid` is produced.
- After reset release, `s_ready` rises at the first `clk` edge.

## Timing
- Busy time from the accept edge to `s_ready` re-rising: `CS_SETUP + 52·CLK_DIV + CS_HOLD + IDLE_GAP` cycles. With defaults: 2+208+2+4 = 216.
- Read latency from the accept edge to `m_rvalid`: `CS_SETUP + 52·CLK_DIV + CS_HOLD` cycles. With defaults: 212.
- Minimum `spi_ss_n` high time between frames: `IDLE_GAP+1` cycles.
- SCK period: `2·CLK_DIV` cycles, 50% duty. SCK is never high while `spi_ss_n`=1.
- Throughput: one command per busy period. No pipelining.

## Configuration
- `PYTHON_SPI_READBACK_EN` defined: read capture, `m_rdata` and `m_rvalid` behave as described above.
- `PYTHON_SPI_READBACK_EN` undefined:
  - `spi_miso` is unused.
  - No capture register.
  - `m_rdata` is tied to 0 and `m_rvalid` to 0.
  - Read commands still shift the full 26-bit frame (MOSI data bits 0) with identical timing.

## Test plan
- Write `s_addr`=9'h0A5, `s_we`=1, `s_wdata`=16'h1234 with defaults → bits sampled on MOSI at SCK rises are `0_1010_0101_1_0001_0010_0011_0100`; no `m_rvalid`; `s_ready` re-rises 216 cycles after accept.
- Read `s_addr`=9'h000 with the sensor model driving 16'h5004 on MISO → MOSI = `000000000_0` followed by 16 zeros; `m_rvalid` pulses once, 212 cycles after accept, with `m_rdata`=16'h5004, held afterwards.
- `s_valid` held high for two back-to-back writes → second accept exactly at `s_ready` re-rise; `spi_ss_n` high for 5 cycles between frames; SCK low throughout.
- `reset_n` pulsed low during bit 10 of a read → `spi_ss_n`=1, `spi_sck`=0, `spi_mosi`=0 asynchronously; no `m_rvalid`; next read completes normally.
- `CLK_DIV`=1, `CS_SETUP`=1, `CS_HOLD`=1, `IDLE_GAP`=0, read returning 16'hFFFF → SCK period 2 cycles; `m_rdata`=16'hFFFF at cycle 54; `s_ready` at cycle 54.
- Build without `PYTHON_SPI_READBACK_EN`, read with MISO=1 → `m_rvalid` never asserts; `m_rdata` stays 0; frame timing unchanged.

Source files
------------

// File: rtl/python_spi_master.sv
// python_spi_master
//   Serializes 26-bit register commands {addr[8:0], we, data[15:0]} MSB first
//   onto the PYTHON300 4-wire SPI port (SPI mode 0, SCK idles low).
//   For read commands, it also returns the 16-bit register value.
//
// Optional feature macro: PYTHON_SPI_READBACK_EN
//   defined   : MISO is captured during read data bits; m_rdata/m_rvalid are live.
//   undefined : MISO is ignored; m_rdata and m_rvalid are tied to 0.
//               Frame timing is identical in both builds.
//
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   s_addr/s_we/s_wdata  : command payload (s_wdata is ignored for reads)
//   s_valid/s_ready      : command handshake
//   m_rdata/m_rvalid     : read result with a one-cycle strobe
//   spi_ss_n/spi_sck/spi_mosi/spi_miso : sensor SPI pins
module python_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  s_addr,
  input  logic        s_we,
  input  logic [15:0] s_wdata,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] m_rdata,
  output logic        m_rvalid,
  output logic        spi_ss_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int PH_MAX = (CS_SETUP > CS_HOLD)
                        ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                        : ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
  // The phase counter counts down from N-1, so it only needs to reach PH_MAX-1.
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  SETUP_LOAD = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LOAD  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]  GAP_LOAD   = PH_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t           state_reg;
  logic [25:0]      frame_reg;
  logic [4:0]       bit_cnt_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [PH_W-1:0]  phase_cnt_reg;

  // Frame bit 16 is the write flag; a cleared flag marks a read.
  logic is_read;
  assign is_read = ~frame_reg[16];

`ifdef PYTHON_SPI_READBACK_EN
  logic [15:0] rx_reg;
  logic [15:0] rdata_reg;
  logic        rvalid_reg;

  assign m_rdata  = rdata_reg;
  assign m_rvalid = rvalid_reg;
`else
  logic unused_miso;
  logic unused_is_read;

  assign unused_miso    = spi_miso;
  assign unused_is_read = is_read;
  assign m_rdata        = 16'h0000;
  assign m_rvalid       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      frame_reg     <= '0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
      phase_cnt_reg <= '0;
      s_ready       <= 1'b0;
      spi_ss_n      <= 1'b1;
      spi_sck       <= 1'b0;
      spi_mosi      <= 1'b0;
`ifdef PYTHON_SPI_READBACK_EN
      rx_reg        <= '0;
      rdata_reg     <= '0;
      rvalid_reg    <= 1'b0;
`endif
    end else begin
`ifdef PYTHON_SPI_READBACK_EN
      rvalid_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (s_ready && s_valid) begin
            // Read data bits are forced to 0 so MOSI stays low during them.
            frame_reg     <= {s_addr, s_we, (s_we ? s_wdata : 16'h0000)};
            s_ready       <= 1'b0;
            spi_ss_n      <= 1'b0;
            spi_mosi      <= s_addr[8];
            phase_cnt_reg <= SETUP_LOAD;
            state_reg     <= ST_SETUP;
          end else begin
            s_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (phase_cnt_reg == '0) begin
            bit_cnt_reg <= 5'd25;
            div_cnt_reg <= DIV_LOAD;
            spi_mosi    <= frame_reg[25];
            state_reg   <= ST_SHIFT;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 1'b1;
          end
        end

        ST_SHIFT: begin
          if (div_cnt_reg != '0) begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end else if (!spi_sck) begin
            // End of the low phase: rising SCK edge, sensor and master sample here.
            spi_sck     <= 1'b1;
            div_cnt_reg <= DIV_LOAD;
`ifdef PYTHON_SPI_READBACK_EN
            if (is_read && (bit_cnt_reg < 5'd16))
              rx_reg <= {rx_reg[14:0], spi_miso};
`endif
          end else begin
            // End of the high phase: SCK falls and the next bit starts.
            spi_sck     <= 1'b0;
            div_cnt_reg <= DIV_LOAD;
            if (bit_cnt_reg == 5'd0) begin
              phase_cnt_reg <= HOLD_LOAD;
              state_reg     <= ST_HOLD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg - 5'd1;
              spi_mosi    <= frame_reg[bit_cnt_reg - 5'd1];
            end
          end
        end

        ST_HOLD: begin
          if (phase_cnt_reg == '0) begin
            spi_ss_n <= 1'b1;
            spi_mosi <= 1'b0;
`ifdef PYTHON_SPI_READBACK_EN
            if (is_read) begin
              rdata_reg  <= rx_reg;
              rvalid_reg <= 1'b1;
            end
`endif
            if (IDLE_GAP == 0) begin
              s_ready   <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              phase_cnt_reg <= GAP_LOAD;
              state_reg     <= ST_GAP;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 1'b1;
          end
        end

        ST_GAP: begin
          if (phase_cnt_reg == '0) begin
            s_ready   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_python_spi_master.sv
// Directed testbench for python_spi_master.
//   u_dut  : default parameters, driven by a small PYTHON300 MISO model.
//   u_fast : CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, IDLE_GAP=0, MISO tied high.
module tb_python_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Default-parameter instance
  logic [8:0]  a1;
  logic        we1;
  logic [15:0] d1;
  logic        v1;
  logic        rdy1;
  logic [15:0] rd1;
  logic        rv1;
  logic        ss1;
  logic        sck1;
  logic        mosi1;
  logic        miso1;

  // Fast instance
  logic [8:0]  a2;
  logic        we2;
  logic [15:0] d2;
  logic        v2;
  logic        rdy2;
  logic [15:0] rd2;
  logic        rv2;
  logic        ss2;
  logic        sck2;
  logic        mosi2;
  logic        miso2;

  python_spi_master u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_addr   (a1),
    .s_we     (we1),
    .s_wdata  (d1),
    .s_valid  (v1),
    .s_ready  (rdy1),
    .m_rdata  (rd1),
    .m_rvalid (rv1),
    .spi_ss_n (ss1),
    .spi_sck  (sck1),
    .spi_mosi (mosi1),
    .spi_miso (miso1)
  );

  python_spi_master #(
    .CLK_DIV  (1),
    .CS_SETUP (1),
    .CS_HOLD  (1),
    .IDLE_GAP (0)
  ) u_fast (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_addr   (a2),
    .s_we     (we2),
    .s_wdata  (d2),
    .s_valid  (v2),
    .s_ready  (rdy2),
    .m_rdata  (rd2),
    .m_rvalid (rv2),
    .spi_ss_n (ss2),
    .spi_sck  (sck2),
    .spi_mosi (mosi2),
    .spi_miso (miso2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc      = 0;
  int acc1_n   = 0;
  int acc1_cyc = 0;
  int acc2_n   = 0;
  int acc2_cyc = 0;
  int rv1_n    = 0;
  int rv1_cyc  = 0;
  int hi_run   = 0;
  int last_hi  = 0;
  int sck_bad  = 0;
  int r1       = 0;
  logic [15:0] sens1 = 16'h0000;
  logic [25:0] mosi_cap = '0;

  // Cycle counter and accept-edge monitors (pre-edge handshake values).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (v1 && rdy1) begin
      acc1_cyc <= cyc + 1;
      acc1_n   <= acc1_n + 1;
    end
    if (v2 && rdy2) begin
      acc2_cyc <= cyc + 1;
      acc2_n   <= acc2_n + 1;
    end
  end

  // Output monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (rv1) begin
      rv1_n   <= rv1_n + 1;
      rv1_cyc <= cyc;
    end
    if (ss1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) last_hi <= hi_run;
      hi_run <= 0;
    end
    if ((ss1 && sck1) || (ss2 && sck2)) sck_bad <= sck_bad + 1;
  end

  // Sensor model: count SCK rises within a frame; present read data MSB first.
  always @(posedge sck1 or posedge ss1) begin
    if (ss1) r1 <= 0;
    else     r1 <= r1 + 1;
  end

  always @(posedge sck1) mosi_cap <= {mosi_cap[24:0], mosi1};

  always_comb begin
    miso1 = 1'b0;
    if (r1 >= 10 && r1 <= 25) miso1 = sens1[4'(25 - r1)];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [8:0] a, input logic w, input logic [15:0] d);
    int start;
    int k;
    @(negedge clk);
    a1 = a; we1 = w; d1 = d; v1 = 1'b1;
    start = acc1_n;
    k = 0;
    while (acc1_n == start && k < 2000) begin
      @(negedge clk);
      k++;
    end
    v1 = 1'b0;
    check("accept", 32'(acc1_n != start), 32'd1);
    $display("[TB] cmd addr=%h we=%0d wdata=%h accepted at cycle %0d", a, w, d, acc1_cyc);
  endtask

  task automatic wait_ready1(output int dt);
    int k;
    k = 0;
    while (!rdy1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    dt = cyc - acc1_cyc;
    check("ready_timeout", 32'(rdy1), 32'd1);
  endtask

  initial begin
    int dt;
    int rvb;
    int start;
    int first;
    int k;
    int base;

    reset_n = 1'b0;
    a1 = '0; we1 = 1'b0; d1 = '0; v1 = 1'b0;
    a2 = '0; we2 = 1'b0; d2 = '0; v2 = 1'b0;
    miso2 = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_s_ready",  32'(rdy1),  32'd0);
    check("rst_m_rdata",  32'(rd1),   32'd0);
    check("rst_m_rvalid", 32'(rv1),   32'd0);
    check("rst_ss_n",     32'(ss1),   32'd1);
    check("rst_sck",      32'(sck1),  32'd0);
    check("rst_mosi",     32'(mosi1), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_first_edge", 32'(rdy1), 32'd1);

    // Write 0x0A5 <= 0x1234
    rvb = rv1_n;
    send1(9'h0A5, 1'b1, 16'h1234);
    wait_ready1(dt);
    check("wr_busy", 32'(dt), 32'd216);
    check("wr_mosi", 32'(mosi_cap), 32'({9'h0A5, 1'b1, 16'h1234}));
    check("wr_no_rvalid", 32'(rv1_n), 32'(rvb));

    // Read 0x000, sensor returns 0x5004 (wdata must not appear on MOSI)
    sens1 = 16'h5004;
    rvb = rv1_n;
    send1(9'h000, 1'b0, 16'hFFFF);
    wait_ready1(dt);
    check("rd_busy", 32'(dt), 32'd216);
    check("rd_mosi", 32'(mosi_cap), 32'd0);
`ifdef PYTHON_SPI_READBACK_EN
    check("rd_rvalid_count", 32'(rv1_n), 32'(rvb + 1));
    check("rd_latency", 32'(rv1_cyc - acc1_cyc), 32'd212);
    check("rd_data", 32'(rd1), 32'h5004);
    repeat (20) @(negedge clk);
    check("rd_data_held", 32'(rd1), 32'h5004);
`else
    check("rd_no_rvalid", 32'(rv1_n), 32'(rvb));
    check("rd_data_zero", 32'(rd1), 32'd0);
`endif

    // Back-to-back writes with s_valid held high
    @(negedge clk);
    a1 = 9'h155; we1 = 1'b1; d1 = 16'hCAFE; v1 = 1'b1;
    start = acc1_n;
    k = 0;
    while (acc1_n == start && k < 2000) begin
      @(negedge clk);
      k++;
    end
    first = acc1_cyc;
    a1 = 9'h0F0; d1 = 16'h0F0F;
    k = 0;
    while (acc1_n < start + 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    v1 = 1'b0;
    $display("[TB] back-to-back accepts at cycles %0d and %0d", first, acc1_cyc);
    check("b2b_second_accept", 32'(acc1_n), 32'(start + 2));
    check("b2b_accept_spacing", 32'(acc1_cyc - first), 32'd217);
    check("b2b_mosi_first", 32'(mosi_cap), 32'({9'h155, 1'b1, 16'hCAFE}));
    @(negedge clk);
    check("b2b_ss_high_cycles", 32'(last_hi), 32'd5);
    wait_ready1(dt);
    check("b2b_busy", 32'(dt), 32'd216);
    check("b2b_mosi_second", 32'(mosi_cap), 32'({9'h0F0, 1'b1, 16'h0F0F}));

    // Reset in the middle of a read (bit 10)
    sens1 = 16'hBEEF;
    rvb = rv1_n;
    send1(9'h1C3, 1'b0, 16'h0000);
    k = 0;
    while (r1 < 16 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reached_bit10", 32'(r1), 32'd16);
    check("bit10_sck_high", 32'(sck1), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ss_n", 32'(ss1),   32'd1);
    check("midrst_sck",  32'(sck1),  32'd0);
    check("midrst_mosi", 32'(mosi1), 32'd0);
    check("midrst_ready", 32'(rdy1), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 32'(rdy1), 32'd1);
    repeat (250) @(negedge clk);
    check("midrst_no_rvalid", 32'(rv1_n), 32'(rvb));
    check("midrst_rdata_cleared", 32'(rd1), 32'd0);

    // Next read completes normally
    sens1 = 16'hA55A;
    rvb = rv1_n;
    send1(9'h1C3, 1'b0, 16'h1111);
    wait_ready1(dt);
    check("rd2_busy", 32'(dt), 32'd216);
    check("rd2_mosi", 32'(mosi_cap), 32'({9'h1C3, 1'b0, 16'h0000}));
`ifdef PYTHON_SPI_READBACK_EN
    check("rd2_rvalid_count", 32'(rv1_n), 32'(rvb + 1));
    check("rd2_data", 32'(rd1), 32'hA55A);
`else
    check("rd2_no_rvalid", 32'(rv1_n), 32'(rvb));
    check("rd2_data_zero", 32'(rd1), 32'd0);
`endif

    // Fast instance: minimum timing, read returning all ones
    @(negedge clk);
    a2 = 9'h03C; we2 = 1'b0; d2 = 16'h0000; v2 = 1'b1;
    start = acc2_n;
    k = 0;
    while (acc2_n == start && k < 200) begin
      @(negedge clk);
      k++;
    end
    v2 = 1'b0;
    check("fast_accept", 32'(acc2_n), 32'(start + 1));
    base = acc2_cyc;
    $display("[TB] fast read addr=03c accepted at cycle %0d", base);
    k = 0;
    while (cyc < base + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("fast_sck_hi0", 32'(sck2), 32'd1);
    @(negedge clk);
    check("fast_sck_lo", 32'(sck2), 32'd0);
    @(negedge clk);
    check("fast_sck_hi1", 32'(sck2), 32'd1);
    k = 0;
    while (cyc < base + 53 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("fast_ready_c53", 32'(rdy2), 32'd0);
    check("fast_rdata_c53", 32'(rd2), 32'd0);
    @(negedge clk);
    check("fast_ready_c54", 32'(rdy2), 32'd1);
    check("fast_ss_c54", 32'(ss2), 32'd1);
`ifdef PYTHON_SPI_READBACK_EN
    check("fast_rvalid_c54", 32'(rv2), 32'd1);
    check("fast_rdata_c54", 32'(rd2), 32'hFFFF);
`else
    check("fast_rvalid_c54", 32'(rv2), 32'd0);
    check("fast_rdata_c54", 32'(rd2), 32'd0);
`endif

    @(negedge clk);
    check("sck_high_with_ss_high", 32'(sck_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
